// File: rtl/lcd_write_scheduler.sv
// Shares a two-row character LCD between two row-owning text producers: round-robin
// per character, set-DDRAM-address insertion only when the cursor is elsewhere, clear sequencing.
module lcd_write_scheduler #(
  parameter int COLS = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_char,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_char,
  output logic       req1_ready,
  input  logic       clr_req,
  output logic       lcd_valid,
  output logic       lcd_rs,
  output logic [7:0] lcd_data,
  input  logic       lcd_ready,
  output logic       busy
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADDR  = 2'd1;
  localparam logic [1:0] S_CHAR  = 2'd2;
  localparam logic [1:0] S_CLEAR = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] col0, col1, cursor_col;
  logic          cursor_valid, cursor_row;
  logic          g, last_grant, clr_pend;
  logic [7:0]    char_q;

  logic          grant_any, grant_sel, need_addr, xfer;
  logic [CW-1:0] col_g, col_sel;

  assign xfer    = lcd_valid & lcd_ready;
  assign col_g   = g ? col1 : col0;
  assign col_sel = grant_sel ? col1 : col0;

  // A pending clear blocks both requesters; a tie goes to whoever did not win last.
  always_comb begin
    grant_any = 1'b0;
    grant_sel = 1'b0;
    if (state == S_IDLE && !clr_pend) begin
      if (req0_valid && req1_valid) begin
        grant_any = 1'b1;
        grant_sel = ~last_grant;
      end else if (req0_valid) begin
        grant_any = 1'b1;
        grant_sel = 1'b0;
      end else if (req1_valid) begin
        grant_any = 1'b1;
        grant_sel = 1'b1;
      end
    end
  end

  assign need_addr = !cursor_valid || (cursor_row != grant_sel) || (cursor_col != col_sel);

  assign req0_ready = reset_n & grant_any & ~grant_sel;
  assign req1_ready = reset_n & grant_any & grant_sel;
  assign busy       = (state != S_IDLE) | clr_pend;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      g          <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (clr_pend) begin
            state <= S_CLEAR;
          end else if (grant_any) begin
            g          <= grant_sel;
            last_grant <= grant_sel;
            state      <= need_addr ? S_ADDR : S_CHAR;
          end
        end
        S_ADDR:  if (xfer) state <= S_CHAR;
        S_CHAR:  if (xfer) state <= S_IDLE;
        S_CLEAR: if (xfer) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Column and cursor tracking mirror the LCD's auto-increment; a row wrap forgets the cursor.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col0         <= '0;
      col1         <= '0;
      cursor_valid <= 1'b0;
      cursor_row   <= 1'b0;
      cursor_col   <= '0;
    end else if (xfer && state == S_CHAR) begin
      if (col_g == LAST_COL) begin
        if (g) col1 <= '0;
        else   col0 <= '0;
        cursor_valid <= 1'b0;
      end else begin
        if (g) col1 <= col1 + COL_ONE;
        else   col0 <= col0 + COL_ONE;
        cursor_row   <= g;
        cursor_col   <= col_g + COL_ONE;
        cursor_valid <= 1'b1;
      end
    end else if (xfer && state == S_CLEAR) begin
      col0         <= '0;
      col1         <= '0;
      cursor_valid <= 1'b1;
      cursor_row   <= 1'b0;
      cursor_col   <= '0;
    end
  end

  // A clear request landing on the clear's own transfer stays pending for another clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_pend <= 1'b0;
    end else if (state == S_CLEAR && xfer) begin
      clr_pend <= clr_req;
    end else if (clr_req) begin
      clr_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (grant_any) char_q <= grant_sel ? req1_char : req0_char;
  end

  always_comb begin
    lcd_valid = 1'b0;
    lcd_rs    = 1'b0;
    lcd_data  = 8'h00;
    case (state)
      S_ADDR: begin
        lcd_valid = 1'b1;
        lcd_data  = 8'h80 | (g ? 8'h40 : 8'h00) | 8'(col_g);
      end
      S_CHAR: begin
        lcd_valid = 1'b1;
        lcd_rs    = 1'b1;
        lcd_data  = char_q;
      end
      S_CLEAR: begin
        lcd_valid = 1'b1;
        lcd_data  = 8'h01;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Bench for lcd_write_scheduler: directed scenarios plus random traffic checked against
// a transaction-level model of the display (where each character must land on the glass).
module tb_lcd_write_scheduler;
  localparam int COLS = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_char, req1_char;
  logic       clr_req;
  logic       lcd_valid, lcd_rs, lcd_ready, busy;
  logic [7:0] lcd_data;

  always #50 clk = ~clk;

  lcd_write_scheduler #(.COLS(COLS)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_char(req0_char), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_char(req1_char), .req1_ready(req1_ready),
    .clr_req(clr_req),
    .lcd_valid(lcd_valid), .lcd_rs(lcd_rs), .lcd_data(lcd_data), .lcd_ready(lcd_ready),
    .busy(busy)
  );

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [7:0] q0[$], q1[$];
  logic [8:0] seen[$], exp_q[$];
  int         t_cyc[$], g_cyc[$];
  logic       g_row[$];
  logic [6:0] p_addr[$];
  logic [7:0] p_char[$];
  int         colm[2];
  int         prev_kind, prev_row, prev_col;
  logic       last_g;
  logic [6:0] lcd_addr;
  int         exp_addr_cnt, act_addr_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete(); seen.delete(); exp_q.delete();
    t_cyc.delete(); g_cyc.delete(); g_row.delete(); p_addr.delete(); p_char.delete();
    colm[0] = 0; colm[1] = 0;
    prev_kind = 0; prev_row = 0; prev_col = 0;
    last_g = 1'b1;
    lcd_addr = 7'd0;
    exp_addr_cnt = 0; act_addr_cnt = 0;
  endtask

  // prev_kind: 0 = cursor unknown, 1 = just cleared, 2 = last char at (prev_row, prev_col)
  task automatic on_grant(input logic r, input logic both);
    logic [7:0] ch;
    bit need;
    if (both) chk("rr_winner", r, !last_g);
    last_g = r;
    ch = r ? q1.pop_front() : q0.pop_front();
    need = !((prev_kind == 1 && r == 1'b0) ||
             (prev_kind == 2 && prev_row == int'(r) && prev_col != COLS - 1));
    if (need) exp_addr_cnt++;
    p_addr.push_back(7'(r ? 64 + colm[r] : colm[r]));
    p_char.push_back(ch);
    prev_kind = 2; prev_row = int'(r); prev_col = colm[r];
    colm[r] = (colm[r] + 1) % COLS;
    g_row.push_back(r);
    g_cyc.push_back(cyc);
  endtask

  task automatic on_xfer(input logic [8:0] v);
    seen.push_back(v);
    t_cyc.push_back(cyc);
    if (v[8]) begin
      chk("char_owner", p_char.size(), 1);
      if (p_char.size() != 0) begin
        chk("char_pos", lcd_addr, p_addr.pop_front());
        chk("char_val", v[7:0], p_char.pop_front());
      end
      lcd_addr++;
    end else if (v[7:0] == 8'h01) begin
      lcd_addr = 7'd0;
      colm[0] = 0; colm[1] = 0;
      prev_kind = 1;
    end else if (v[7]) begin
      lcd_addr = v[6:0];
      act_addr_cnt++;
    end
  endtask

  task automatic step();
    req0_valid = (q0.size() != 0);
    req0_char  = (q0.size() != 0) ? q0[0] : 8'h00;
    req1_valid = (q1.size() != 0);
    req1_char  = (q1.size() != 0) ? q1[0] : 8'h00;
    #10;
    if (req0_ready || req1_ready) begin
      chk("one_ready", {req0_ready, req1_ready} == 2'b11, 0);
      on_grant(req1_ready, req0_valid && req1_valid);
    end
    if (lcd_valid && lcd_ready) on_xfer({lcd_rs, lcd_data});
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_idle(input int max, output int idle_at);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || busy || lcd_valid) && n < max) begin
      step();
      n++;
    end
    chk("idle_reached", n < max, 1);
    idle_at = cyc;
  endtask

  task automatic expect_seq(input string tag);
    chk({tag, "_len"}, seen.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < seen.size(); i++) chk(tag, seen[i], exp_q[i]);
    exp_q.delete(); seen.delete(); t_cyc.delete(); g_cyc.delete(); g_row.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; clr_req = 1'b0; lcd_ready = 1'b0;
    q0.delete(); q1.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int ia, n;
    reset_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_char = 8'h00; req1_char = 8'h00;
    clr_req = 1'b0; lcd_ready = 1'b0;
    model_reset();

    // Reset state, with both requesters pushing during reset
    #5 reset_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #15;
    chk("rst_lcd_valid", lcd_valid, 0);
    chk("rst_lcd_rs", lcd_rs, 0);
    chk("rst_lcd_data", lcd_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    repeat (2) @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset_n = 1'b1;

    // First characters on each row
    lcd_ready = 1'b1;
    q0.push_back(8'h48);
    run_idle(20, ia);
    chk("h_lat_addr", t_cyc[0] - g_cyc[0], 1);
    chk("h_lat_char", t_cyc[1] - g_cyc[0], 2);
    chk("h_busy_fall", ia - t_cyc[1], 1);
    exp_q.push_back(9'h080); exp_q.push_back(9'h148);
    expect_seq("first_h");
    q1.push_back(8'h57);
    run_idle(20, ia);
    exp_q.push_back(9'h0C0); exp_q.push_back(9'h157);
    expect_seq("first_w");

    // Contiguous row
    do_reset();
    lcd_ready = 1'b1;
    q0.push_back(8'h41); q0.push_back(8'h42); q0.push_back(8'h43);
    run_idle(30, ia);
    chk("abc_gap1", g_cyc[1] - g_cyc[0], 3);
    chk("abc_gap2", g_cyc[2] - g_cyc[1], 2);
    chk("b_lat_char", t_cyc[2] - g_cyc[1], 1);
    chk("abc_addr_cnt", act_addr_cnt, exp_addr_cnt);
    exp_q.push_back(9'h080); exp_q.push_back(9'h141);
    exp_q.push_back(9'h142); exp_q.push_back(9'h143);
    expect_seq("contig");

    // Round-robin with both requesters continuously valid
    do_reset();
    lcd_ready = 1'b1;
    q0.push_back(8'h61); q0.push_back(8'h62);
    q1.push_back(8'h63); q1.push_back(8'h64);
    run_idle(40, ia);
    chk("rr_g0", g_row[0], 0);
    chk("rr_g1", g_row[1], 1);
    chk("rr_g2", g_row[2], 0);
    chk("rr_g3", g_row[3], 1);
    exp_q.push_back(9'h080); exp_q.push_back(9'h161);
    exp_q.push_back(9'h0C0); exp_q.push_back(9'h163);
    exp_q.push_back(9'h081); exp_q.push_back(9'h162);
    exp_q.push_back(9'h0C1); exp_q.push_back(9'h164);
    expect_seq("rr");

    // Row wrap after COLS characters
    do_reset();
    lcd_ready = 1'b1;
    for (int i = 0; i < COLS + 1; i++) q0.push_back(8'(8'h61 + i));
    run_idle(100, ia);
    chk("wrap_addr_cnt", act_addr_cnt, 2);
    chk("wrap_addr_model", act_addr_cnt, exp_addr_cnt);
    exp_q.push_back(9'h080);
    for (int i = 0; i < COLS; i++) exp_q.push_back({1'b1, 8'(8'h61 + i)});
    exp_q.push_back(9'h080);
    exp_q.push_back({1'b1, 8'(8'h61 + COLS)});
    expect_seq("wrap");

    // Clear arriving during a stalled character
    do_reset();
    lcd_ready = 1'b1;
    q0.push_back(8'h48);
    run_idle(20, ia);
    exp_q.push_back(9'h080); exp_q.push_back(9'h148);
    expect_seq("pre_clr");
    lcd_ready = 1'b0;
    q0.push_back(8'h58);
    step();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (4) step();
    chk("stall_valid", lcd_valid, 1);
    chk("stall_rs", lcd_rs, 1);
    chk("stall_data", lcd_data, 8'h58);
    chk("stall_busy", busy, 1);
    lcd_ready = 1'b1;
    run_idle(20, ia);
    exp_q.push_back(9'h158); exp_q.push_back(9'h001);
    expect_seq("clr_after_char");
    q0.push_back(8'h50);
    run_idle(20, ia);
    exp_q.push_back(9'h150);
    expect_seq("post_clr_row0");
    q1.push_back(8'h51);
    run_idle(20, ia);
    exp_q.push_back(9'h0C0); exp_q.push_back(9'h151);
    expect_seq("post_clr_row1");

    // Second clear request on the clear's transfer cycle
    lcd_ready = 1'b0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    n = 0;
    while (!(lcd_valid && lcd_data == 8'h01) && n < 10) begin
      step();
      n++;
    end
    chk("clr_reached", lcd_valid && lcd_data == 8'h01, 1);
    lcd_ready = 1'b1;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    run_idle(20, ia);
    exp_q.push_back(9'h001); exp_q.push_back(9'h001);
    expect_seq("double_clr");

    // Asynchronous reset in the middle of a stalled character
    do_reset();
    lcd_ready = 1'b1;
    q0.push_back(8'h48);
    run_idle(20, ia);
    exp_q.push_back(9'h080); exp_q.push_back(9'h148);
    expect_seq("pre_rst");
    lcd_ready = 1'b0;
    q0.push_back(8'h49);
    step();
    repeat (3) begin
      step();
      chk("hold_valid", lcd_valid, 1);
      chk("hold_rs", lcd_rs, 1);
      chk("hold_data", lcd_data, 8'h49);
    end
    req0_valid = 1'b1; req0_char = 8'h4A;
    #10;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_lcd_valid", lcd_valid, 0);
    chk("mid_rst_lcd_rs", lcd_rs, 0);
    chk("mid_rst_lcd_data", lcd_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_req0_ready", req0_ready, 0);
    chk("mid_rst_req1_ready", req1_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    q0.push_back(8'h4A);
    lcd_ready = 1'b1;
    run_idle(20, ia);
    exp_q.push_back(9'h080); exp_q.push_back(9'h14A);
    expect_seq("post_rst");

    // Random traffic, backpressure and clears against the display model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0 && q0.size() < 3) q0.push_back(8'($urandom_range(32, 126)));
      if ($urandom_range(0, 3) == 0 && q1.size() < 3) q1.push_back(8'($urandom_range(32, 126)));
      lcd_ready = ($urandom_range(0, 3) != 0);
      clr_req = ($urandom_range(0, 39) == 0);
      step();
    end
    clr_req = 1'b0;
    lcd_ready = 1'b1;
    run_idle(300, ia);
    chk("rnd_addr_cnt", act_addr_cnt, exp_addr_cnt);
    chk("rnd_pending", p_char.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
